udp_char_buffer: RTL and testbench

Ingress stage that feeds the OSD character overlay. It receives the UDP payload byte stream, already moved into the video_clk domain by the upstream async FIFO, and checks a 2-byte header. Accepted payload characters go into the back bank of a ping-pong character RAM. The banks swap only on a rising edge of video_vsync, so osd_display never reads a half-written string through ram_read_addr/ram_rdata.

---
 rtl/udp_char_pkg.sv | 25 ++
 rtl/udp_char_buffer_dpram.sv | 31 +++
 rtl/udp_char_buffer.sv | 164 ++++++++++++++++
 tb/tb_udp_char_buffer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_char_pkg.sv
// Shared definitions for the UDP character buffer: default parameters,
// header-parser state encoding and a saturating counter helper.
package udp_char_pkg;

  localparam int         DEF_ADDR_W = 11;
  localparam logic [7:0] DEF_MAGIC  = 8'hA5;
  localparam logic [2:0] DEF_MAX_CH = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR1    = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_t;

  function automatic logic [7:0] sat_add(
    input logic [7:0] cnt,
    input logic [1:0] inc
  );
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/udp_char_buffer_dpram.sv
// Ping-pong character RAM: two banks of 2^ADDR_W bytes, bank selected by
// the address MSB. Ports: clk, rst, we/waddr/wdata, raddr -> rdata (1 cycle).
module char_dpram
  import udp_char_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [ADDR_W:0] waddr,
  input  logic [7:0]      wdata,
  input  logic [ADDR_W:0] raddr,
  output logic [7:0]      rdata
);

  localparam int DEPTH = 1 << (ADDR_W + 1);

  logic [7:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register clears on reset so the read port starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_char_buffer.sv
// UDP payload ingress for the OSD: parses the 2-byte header, writes the
// payload into the back bank and swaps banks on a rising video_vsync.
// Ports: udp_rx_* byte stream in, video_vsync, ram_read_addr/ram_rdata read
// port, status outputs udp_rec_data_valid, char_count, char_ch,
// frame_update and drop_cnt.
module udp_char_buffer
  import udp_char_pkg::*;
#(
  parameter int         ADDR_W = DEF_ADDR_W,
  parameter logic [7:0] MAGIC  = DEF_MAGIC,
  parameter logic [2:0] MAX_CH = DEF_MAX_CH
) (
  input  logic              video_clk,
  input  logic              rst,
  input  logic [7:0]        udp_rx_data,
  input  logic              udp_rx_valid,
  input  logic              udp_rx_sop,
  input  logic              udp_rx_eop,
  input  logic              udp_rx_err,
  input  logic              video_vsync,
  input  logic [ADDR_W-1:0] ram_read_addr,
  output logic [7:0]        ram_rdata,
  output logic              udp_rec_data_valid,
  output logic [ADDR_W:0]   char_count,
  output logic [2:0]        char_ch,
  output logic              frame_update,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  state_t          state;
  state_t          state_n;
  logic [ADDR_W:0] wr_cnt;
  logic [ADDR_W:0] pend_count;
  logic [ADDR_W:0] commit_cnt;
  logic [2:0]      ch_w;
  logic [2:0]      pend_ch;
  logic            pending;
  logic            pend_n;
  logic            front;
  logic            vsync_d;
  logic            vsync_rise;
  logic            swap;
  logic            we;
  logic            hdr_ok;
  logic            hdr_good;
  logic            commit;
  logic [1:0]      drops;

  assign hdr_good = (udp_rx_data[7:3] == 5'd0)
                  && (int'(udp_rx_data[2:0]) <= int'(MAX_CH));

  always_comb begin
    state_n = state;
    drops   = 2'd0;
    we      = 1'b0;
    hdr_ok  = 1'b0;
    commit  = 1'b0;
    if (udp_rx_valid) begin
      if (udp_rx_sop && state != DROP) begin
        // A sop mid-datagram aborts it, then starts over as from IDLE.
        if (state == HDR1 || state == PAYLOAD) drops = 2'd1;
        if (udp_rx_eop || udp_rx_data != MAGIC) begin
          drops   = drops + 2'd1;
          state_n = udp_rx_eop ? IDLE : DROP;
        end else begin
          state_n = HDR1;
        end
      end else begin
        unique case (state)
          IDLE: state_n = IDLE;
          HDR1: begin
            if (udp_rx_eop) begin
              drops   = 2'd1;
              state_n = IDLE;
            end else if (hdr_good) begin
              hdr_ok  = 1'b1;
              state_n = PAYLOAD;
            end else begin
              drops   = 2'd1;
              state_n = DROP;
            end
          end
          PAYLOAD: begin
            if (wr_cnt[ADDR_W]) begin
              drops   = 2'd1;
              state_n = udp_rx_eop ? IDLE : DROP;
            end else begin
              we = 1'b1;
              if (udp_rx_eop) begin
                state_n = IDLE;
                if (udp_rx_err) drops  = 2'd1;
                else            commit = 1'b1;
              end
            end
          end
          DROP: if (udp_rx_eop) state_n = IDLE;
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Accepting a new header means the back bank is about to be rewritten,
  // so any pending string is withdrawn. A commit this cycle feeds the swap.
  assign commit_cnt = wr_cnt + CNT_ONE;
  assign vsync_rise = video_vsync & ~vsync_d;
  assign pend_n     = commit | (pending & ~hdr_ok);
  assign swap       = vsync_rise & pend_n;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      wr_cnt             <= '0;
      pend_count         <= '0;
      ch_w               <= '0;
      pend_ch            <= '0;
      pending            <= 1'b0;
      front              <= 1'b0;
      vsync_d            <= 1'b0;
      udp_rec_data_valid <= 1'b0;
      char_count         <= '0;
      char_ch            <= '0;
      frame_update       <= 1'b0;
      drop_cnt           <= '0;
    end else begin
      state        <= state_n;
      vsync_d      <= video_vsync;
      drop_cnt     <= sat_add(drop_cnt, drops);
      pending      <= pend_n & ~swap;
      frame_update <= swap;
      if (hdr_ok) begin
        ch_w   <= udp_rx_data[2:0];
        wr_cnt <= '0;
      end else if (we) begin
        wr_cnt <= commit_cnt;
      end
      if (commit) begin
        pend_count <= commit_cnt;
        pend_ch    <= ch_w;
      end
      if (swap) begin
        front              <= ~front;
        udp_rec_data_valid <= 1'b1;
        char_count         <= commit ? commit_cnt : pend_count;
        char_ch            <= commit ? ch_w : pend_ch;
      end
    end
  end

  char_dpram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (video_clk),
    .rst   (rst),
    .we    (we),
    .waddr ({~front, wr_cnt[ADDR_W-1:0]}),
    .wdata (udp_rx_data),
    .raddr ({front, ram_read_addr}),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_udp_char_buffer.sv
// Randomized scoreboard bench for udp_char_buffer: a datagram-level model
// predicts swaps and drop counts; a monitor checks them and the front bank.
module tb_udp_char_buffer;

  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;

  logic          video_clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    udp_rx_data = '0;
  logic          udp_rx_valid = 1'b0;
  logic          udp_rx_sop = 1'b0;
  logic          udp_rx_eop = 1'b0;
  logic          udp_rx_err = 1'b0;
  logic          video_vsync = 1'b0;
  logic [AW-1:0] ram_read_addr = '0;
  logic [7:0]    ram_rdata;
  logic          udp_rec_data_valid;
  logic [AW:0]   char_count;
  logic [2:0]    char_ch;
  logic          frame_update;
  logic [7:0]    drop_cnt;

  always #5 video_clk = ~video_clk;

  udp_char_buffer dut (
    .video_clk          (video_clk),
    .rst                (rst),
    .udp_rx_data        (udp_rx_data),
    .udp_rx_valid       (udp_rx_valid),
    .udp_rx_sop         (udp_rx_sop),
    .udp_rx_eop         (udp_rx_eop),
    .udp_rx_err         (udp_rx_err),
    .video_vsync        (video_vsync),
    .ram_read_addr      (ram_read_addr),
    .ram_rdata          (ram_rdata),
    .udp_rec_data_valid (udp_rec_data_valid),
    .char_count         (char_count),
    .char_ch            (char_ch),
    .frame_update       (frame_update),
    .drop_cnt           (drop_cnt)
  );

  typedef struct {
    int base;
    int cnt;
    int ch;
  } swap_t;

  int         n_checks = 0;
  int         n_fail = 0;
  swap_t      swap_q[$];
  int         drop_q[$];
  logic [7:0] store [0:65535];
  int         store_top = 0;
  logic [7:0] pkt [0:2100];
  bit         m_pend = 0;
  int         m_base = 0;
  int         m_cnt = 0;
  int         m_ch = 0;
  int         m_drop = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_ev(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  // ---------------- reference model (datagram level) ----------------
  task automatic add_drop();
    if (m_drop < 255) begin
      m_drop++;
      drop_q.push_back(m_drop);
    end
  endtask

  task automatic model_vsync();
    swap_t e;
    if (m_pend) begin
      e.base = m_base;
      e.cnt  = m_cnt;
      e.ch   = m_ch;
      swap_q.push_back(e);
      m_pend = 0;
    end
  endtask

  task automatic model_dgram(input int n, input bit eop_en, input bit e);
    bit hdr;
    int plen;
    plen = n - 2;
    hdr  = (n >= 2) && (pkt[0] == 8'hA5) && (pkt[1] <= 8'd7)
        && (n >= 3 || !eop_en);
    if (hdr) m_pend = 0;
    if (!eop_en || !hdr || plen > DEPTH || e) begin
      add_drop();
    end else begin
      for (int i = 0; i < plen; i++) store[store_top+i] = pkt[2+i];
      m_base = store_top;
      m_cnt  = plen;
      m_ch   = int'(pkt[1]);
      m_pend = 1;
      store_top += plen;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send(input int n, input bit eop_en, input bit e,
                      input bit vs_eop);
    model_dgram(n, eop_en, e);
    for (int i = 0; i < n; i++) begin
      @(negedge video_clk);
      while ($urandom_range(0, 3) == 0) begin
        udp_rx_valid = 1'b0;
        udp_rx_data  = 8'($urandom);
        udp_rx_sop   = 1'($urandom);
        udp_rx_eop   = 1'($urandom);
        udp_rx_err   = 1'($urandom);
        @(negedge video_clk);
      end
      udp_rx_valid = 1'b1;
      udp_rx_data  = pkt[i];
      udp_rx_sop   = (i == 0);
      udp_rx_eop   = eop_en && (i == n - 1);
      udp_rx_err   = (i == n - 1) ? e : 1'($urandom);
      if (vs_eop && i == n - 1) begin
        video_vsync = 1'b1;
        model_vsync();
      end
    end
    @(negedge video_clk);
    udp_rx_valid = 1'b0;
    udp_rx_sop   = 1'b0;
    udp_rx_eop   = 1'b0;
    udp_rx_err   = 1'b0;
    if (vs_eop) begin
      repeat (3) @(negedge video_clk);
      video_vsync = 1'b0;
      repeat (20) @(negedge video_clk);
    end
  endtask

  task automatic vs_pulse();
    @(negedge video_clk);
    video_vsync = 1'b1;
    model_vsync();
    repeat (3) @(negedge video_clk);
    video_vsync = 1'b0;
    repeat (20) @(negedge video_clk);
  endtask

  task automatic fill(input int b0, input int b1, input int plen);
    pkt[0] = 8'(b0);
    pkt[1] = 8'(b1);
    for (int i = 0; i < plen; i++) pkt[2+i] = 8'($urandom_range(32, 126));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdata"}, ram_rdata, 0);
    chk({tag, "_valid"}, udp_rec_data_valid, 0);
    chk({tag, "_count"}, char_count, 0);
    chk({tag, "_ch"}, char_ch, 0);
    chk({tag, "_fu"}, frame_update, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit         cur_valid;
    int         cur_base;
    int         cur_cnt;
    int         cur_ch;
    bit         rd_pend;
    logic [7:0] rd_exp;
    int         last_drop;
    int         a;
    swap_t      e;
    cur_valid = 0;
    cur_base  = 0;
    cur_cnt   = 0;
    cur_ch    = 0;
    rd_pend   = 0;
    rd_exp    = '0;
    last_drop = 0;
    forever begin
      @(negedge video_clk);
      if (rst) begin
        cur_valid = 0;
        cur_cnt   = 0;
        cur_ch    = 0;
        rd_pend   = 0;
        last_drop = 0;
        continue;
      end
      if (rd_pend) chk("rdata", ram_rdata, rd_exp);
      if (int'(drop_cnt) != last_drop) begin
        if (drop_q.size() == 0) fail_ev("drop_cnt", drop_cnt);
        else chk("drop_cnt", drop_cnt, drop_q.pop_front());
        last_drop = int'(drop_cnt);
      end
      if (frame_update) begin
        if (swap_q.size() == 0) begin
          fail_ev("frame_update", frame_update);
        end else begin
          e = swap_q.pop_front();
          cur_valid = 1;
          cur_base  = e.base;
          cur_cnt   = e.cnt;
          cur_ch    = e.ch;
        end
      end
      chk("rec_valid", udp_rec_data_valid, cur_valid);
      chk("char_count", char_count, cur_cnt);
      chk("char_ch", char_ch, cur_ch);
      rd_pend = 0;
      if (cur_valid) begin
        a = $urandom_range(0, cur_cnt - 1);
        ram_read_addr = AW'(a);
        rd_exp = store[cur_base+a];
        rd_pend = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    int plen;
    repeat (3) @(negedge video_clk);
    check_zero("reset");
    @(posedge video_clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge video_clk);

    fill(8'hA5, 2, 0);
    pkt[2] = "H";
    pkt[3] = "I";
    send(4, 1, 0, 0);
    repeat (5) @(negedge video_clk);
    vs_pulse();

    fill(8'hA5, 5, 3);
    send(5, 1, 0, 0);
    repeat (30) @(negedge video_clk);
    vs_pulse();

    fill(8'h5A, 1, 3);
    send(5, 1, 0, 0);
    vs_pulse();

    fill(8'hA5, 1, DEPTH + 1);
    send(DEPTH + 3, 1, 0, 0);
    vs_pulse();

    fill(8'hA5, 7, DEPTH);
    send(DEPTH + 2, 1, 0, 0);
    vs_pulse();

    fill(8'hA5, 3, 0);
    pkt[2] = "A";
    pkt[3] = "B";
    send(4, 1, 0, 0);
    fill(8'hA5, 4, 0);
    pkt[2] = "X";
    pkt[3] = "Y";
    pkt[4] = "Z";
    send(5, 1, 0, 0);
    vs_pulse();

    fill(8'hA5, 6, 2);
    send(4, 1, 0, 1);

    fill(8'hA5, 0, 3);
    send(5, 0, 0, 0);
    fill(8'hA5, 1, 4);
    send(6, 1, 0, 0);
    vs_pulse();

    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 5);
      plen = $urandom_range(1, 12);
      if (kind <= 1 && $urandom_range(0, 3) == 0) begin
        fill(8'hA5, $urandom_range(0, 7), plen);
        send(plen + 2, 0, 0, 0);
      end
      case (kind)
        0, 1: begin
          fill(8'hA5, $urandom_range(0, 7), plen);
          send(plen + 2, 1, 0, $urandom_range(0, 5) == 0);
        end
        2: begin
          fill($urandom_range(0, 255), 1, plen);
          if (pkt[0] == 8'hA5) pkt[0] = 8'h5A;
          send(plen + 2, 1, 0, 0);
        end
        3: begin
          fill(8'hA5, $urandom_range(8, 255), plen);
          send(plen + 2, 1, 0, 0);
        end
        4: begin
          fill(8'hA5, $urandom_range(0, 7), 0);
          send(2, 1, 0, 0);
        end
        default: begin
          fill(8'hA5, $urandom_range(0, 7), plen);
          send(plen + 2, 1, 1, 0);
        end
      endcase
      if ($urandom_range(0, 2) == 0) vs_pulse();
    end
    vs_pulse();

    fill(8'hA5, 2, 20);
    for (int i = 0; i < 10; i++) begin
      @(negedge video_clk);
      udp_rx_valid = 1'b1;
      udp_rx_data  = pkt[i];
      udp_rx_sop   = (i == 0);
      udp_rx_eop   = 1'b0;
    end
    @(posedge video_clk);
    #2;
    rst = 1'b1;
    udp_rx_valid = 1'b0;
    udp_rx_sop = 1'b0;
    swap_q.delete();
    drop_q.delete();
    m_pend = 0;
    m_drop = 0;
    repeat (2) @(negedge video_clk);
    check_zero("midrst");
    @(posedge video_clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge video_clk);
    fill(8'hA5, 3, 6);
    send(8, 1, 0, 0);
    vs_pulse();

    for (int i = 0; i < 300; i++) begin
      fill(8'h5A, $urandom_range(0, 255), 0);
      send(2, 1, 0, 0);
    end

    repeat (30) @(negedge video_clk);
    chk("drop_final", drop_cnt, m_drop);
    chk("swaps_left", swap_q.size(), 0);
    chk("drops_left", drop_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
